// File: rtl/ram_loader_if.sv
// Signal bundle for ram_loader: byte stream in, CPU bus in, RAM port and status out.
// master = stream source / CPU / RAM side, slave = the loader itself.
interface ram_loader_if #(
    parameter int Bits = 16
);
    logic [7:0]      rxData;
    logic            rxValid;
    logic            rxReady;
    logic [Bits-1:0] cpuAddress;
    logic [7:0]      cpuDataIn;
    logic            cpuWrite;
    logic [Bits-1:0] ramAddress;
    logic [7:0]      ramDataIn;
    logic            ramWrite;
    logic            busy;
    logic            done;
    logic            error;

    modport master (
        output rxData, rxValid, cpuAddress, cpuDataIn, cpuWrite,
        input  rxReady, ramAddress, ramDataIn, ramWrite, busy, done, error
    );

    modport slave (
        input  rxData, rxValid, cpuAddress, cpuDataIn, cpuWrite,
        output rxReady, ramAddress, ramDataIn, ramWrite, busy, done, error
    );
endinterface

// File: rtl/ram_loader.sv
// Framed byte-stream boot loader that owns the RAM write port and passes CPU traffic through when idle.
// Define RAM_LOADER_CHECKSUM_EN to add the trailing checksum byte and the sticky error flag.
module ram_loader #(
    parameter int Bits = 16
) (
    input logic         clk,
    input logic         reset,
    ram_loader_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR_HI,
        S_ADDR_LO,
        S_LEN_HI,
        S_LEN_LO,
        S_DATA,
        S_CHECK
    } state_t;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    state_t          r_state;
    state_t          w_state_next;
    logic            w_accept;
    logic            w_start;
    logic            w_data_byte;
    logic            w_finish_now;
    logic            w_frame_end;
    logic            w_loader_owns;

    logic [7:0]      r_hi;
    logic [Bits-1:0] r_addr;
    logic [Bits-1:0] r_wr_addr;
    logic [7:0]      r_wr_data;
    logic [15:0]     r_remaining;
    logic            r_wr_pend;
    logic            r_fin_pend;
    logic            r_busy;
    logic            r_done;
`ifdef RAM_LOADER_CHECKSUM_EN
    logic [7:0]      r_sum;
    logic            r_error;
    logic            w_chk_bad;
`endif

    // The loader never back-pressures, so every valid byte is accepted.
    assign w_accept = bus.rxValid;

    // NOTE: sequential state is assigned with <= only, so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_data_byte  = 1'b0;
        w_finish_now = 1'b0;
`ifdef RAM_LOADER_CHECKSUM_EN
        w_chk_bad    = 1'b0;
`endif
        if (w_accept) begin
            case (r_state)
                S_IDLE: begin
                    if (bus.rxData == SYNC_BYTE) begin
                        w_state_next = S_ADDR_HI;
                        w_start      = 1'b1;
                    end
                end
                S_ADDR_HI: w_state_next = S_ADDR_LO;
                S_ADDR_LO: w_state_next = S_LEN_HI;
                S_LEN_HI:  w_state_next = S_LEN_LO;
                S_LEN_LO: begin
                    if ({r_hi, bus.rxData} == 16'd0) begin
`ifdef RAM_LOADER_CHECKSUM_EN
                        w_state_next = S_CHECK;
`else
                        w_state_next = S_IDLE;
                        w_finish_now = 1'b1;
`endif
                    end else begin
                        w_state_next = S_DATA;
                    end
                end
                S_DATA: begin
                    w_data_byte = 1'b1;
                    if (r_remaining == 16'd1) begin
`ifdef RAM_LOADER_CHECKSUM_EN
                        w_state_next = S_CHECK;
`else
                        w_state_next = S_IDLE;
`endif
                    end
                end
`ifdef RAM_LOADER_CHECKSUM_EN
                S_CHECK: begin
                    w_state_next = S_IDLE;
                    w_finish_now = 1'b1;
                    w_chk_bad    = (bus.rxData != r_sum);
                end
`endif
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    // A frame whose last data byte was just taken finishes one cycle later, after its write.
    assign w_frame_end = w_finish_now || r_fin_pend;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_pend  <= 1'b0;
            r_fin_pend <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_wr_pend  <= w_data_byte;
            r_fin_pend <= w_data_byte && (w_state_next == S_IDLE);
            r_done     <= w_frame_end;
            if (w_start) begin
                r_busy <= 1'b1;
            end else if (w_frame_end) begin
                r_busy <= 1'b0;
            end
        end
    end

    // NOTE: payload registers carry no reset; nothing reads them until the FSM or r_wr_pend qualifies them.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            case (r_state)
                S_ADDR_HI, S_LEN_HI: r_hi <= bus.rxData;
                S_ADDR_LO:           r_addr <= Bits'({r_hi, bus.rxData});
                S_LEN_LO:            r_remaining <= {r_hi, bus.rxData};
                S_DATA: begin
                    r_wr_addr   <= r_addr;
                    r_wr_data   <= bus.rxData;
                    r_addr      <= r_addr + Bits'(1);
                    r_remaining <= r_remaining - 16'd1;
                end
                default: ;
            endcase
        end
    end

`ifdef RAM_LOADER_CHECKSUM_EN
    // Running sum covers the four header bytes after the sync and every data byte.
    always_ff @(posedge clk) begin
        if (w_start) begin
            r_sum <= 8'h00;
        end else if (w_accept && (r_state != S_IDLE) && (r_state != S_CHECK)) begin
            r_sum <= r_sum + bus.rxData;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_error <= 1'b0;
        end else if (w_start) begin
            r_error <= 1'b0;
        end else if (w_chk_bad) begin
            r_error <= 1'b1;
        end
    end

    assign bus.error = r_error;
`else
    assign bus.error = 1'b0;
`endif

    // The CPU keeps the RAM only while no frame is open and no loader write is in flight.
    assign w_loader_owns  = r_busy || r_wr_pend;
    assign bus.ramAddress = w_loader_owns ? r_wr_addr : bus.cpuAddress;
    assign bus.ramDataIn  = w_loader_owns ? r_wr_data : bus.cpuDataIn;
    assign bus.ramWrite   = !reset && (w_loader_owns ? r_wr_pend : bus.cpuWrite);

    assign bus.rxReady = 1'b1;
    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
endmodule
